// File: rtl/hand_jog_controller.sv
// hand_jog_controller: button-driven three-axis hand-point generator.
// Six push buttons jog a bottom hand point in X, Y and Z once per motion
// tick, with per-axis hold acceleration and wrap or saturate boundaries.
// A top point follows at a fixed vertical span above the bottom point.
// hand_valid pulses for one cycle whenever a tick actually moved a point.
// Optional feature: define HAND_JOG_DEBOUNCE_EN to add a per-button
// debouncer (parameter DEBOUNCE_CYCLES) behind the synchronisers.

module hand_jog_controller #(
`ifdef HAND_JOG_DEBOUNCE_EN
    parameter int DEBOUNCE_CYCLES = 65000,
`endif
    parameter int TICK_CYCLES = 1625000,
    parameter int XY_W        = 12,
    parameter int Z_W         = 14,
    parameter int MAX_X       = 3400,
    parameter int MAX_Y       = 3400,
    parameter int MAX_Z       = 500,
    parameter int X_INIT      = 1800,
    parameter int Y_INIT      = 1800,
    parameter int Z_INIT      = 0,
    parameter int SPAN_Y      = 200,
    parameter int BASE_SPEED  = 18,
    parameter int MAX_SPEED   = 72,
    parameter int ACCEL_STEP  = 18,
    parameter int ACCEL_TICKS = 8,
    parameter int WRAP_MODE   = 1
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            left_button,
    input  logic            right_button,
    input  logic            up_button,
    input  logic            down_button,
    input  logic            fwd_button,
    input  logic            back_button,
    output logic [XY_W-1:0] hand_x_left_bottom,
    output logic [XY_W-1:0] hand_y_left_bottom,
    output logic [Z_W-1:0]  hand_z_left_bottom,
    output logic [XY_W-1:0] hand_x_left_top,
    output logic [XY_W-1:0] hand_y_left_top,
    output logic [Z_W-1:0]  hand_z_left_top,
    output logic            hand_valid
);

    // Signed working width: wide enough that pos + delta never overflows.
    localparam int CW = ((XY_W > Z_W) ? XY_W : Z_W) + 2;
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HW = $clog2(ACCEL_TICKS + 1);

    // Per-axis direction encoding, remembered from one tick to the next.
    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_POS  = 2'd1;
    localparam logic [1:0] DIR_NEG  = 2'd2;

    typedef struct packed {
        logic signed [CW-1:0] pos;
        logic [CW-1:0]        speed;
        logic [HW-1:0]        hold;
        logic [1:0]           dir;
    } axis_t;

    // Bit order: 0 left (X-), 1 right (X+), 2 up (Y-), 3 down (Y+),
    // 4 back (Z-), 5 fwd (Z+).
    logic [5:0] btn_raw;
    logic [5:0] sync_a;
    logic [5:0] sync_b;
    logic [5:0] btn_level;

    logic [TW-1:0] tick_cnt;
    logic          tick;

    logic [XY_W-1:0] x_q;
    logic [XY_W-1:0] y_q;
    logic [Z_W-1:0]  z_q;
    logic [XY_W-1:0] top_y_q;

    logic [CW-1:0] speed_q [3];
    logic [HW-1:0] hold_q  [3];
    logic [1:0]    dir_q   [3];

    axis_t                cur_x, cur_y, cur_z;
    axis_t                nxt_x, nxt_y, nxt_z;
    logic signed [CW-1:0] top_y_next;
    logic                 moved;

    // Wrap or clamp a candidate coordinate into 0..limit-1.
    function automatic logic signed [CW-1:0] apply_bound(input logic signed [CW-1:0] n,
                                                         input int limit);
        logic signed [CW-1:0] lim;
        lim = CW'(limit);
        if (WRAP_MODE != 0) begin
            if (n >= lim)       return n - lim;
            else if (n[CW-1])   return n + lim;
            else                return n;
        end else begin
            if (n >= lim)       return lim - CW'(1);
            else if (n[CW-1])   return '0;
            else                return n;
        end
    endfunction

    // One tick of motion for a single axis: direction, speed ramp, new position.
    function automatic axis_t step_axis(input axis_t cur, input logic neg_btn,
                                        input logic pos_btn, input int limit);
        axis_t                nxt;
        logic [1:0]           dir;
        logic signed [CW-1:0] delta;
        logic [CW-1:0]        grown;
        nxt   = cur;
        dir   = DIR_NONE;
        delta = '0;
        grown = '0;
        if (neg_btn && !pos_btn)      dir = DIR_NEG;
        else if (pos_btn && !neg_btn) dir = DIR_POS;
        if (dir == DIR_NONE) begin
            nxt.speed = CW'(BASE_SPEED);
            nxt.hold  = '0;
        end else begin
            if (dir != cur.dir) begin
                delta     = CW'(BASE_SPEED);
                nxt.speed = CW'(BASE_SPEED);
                nxt.hold  = HW'(1);
            end else begin
                delta = $signed(cur.speed);
                if (cur.hold + HW'(1) == HW'(ACCEL_TICKS)) begin
                    grown     = cur.speed + CW'(ACCEL_STEP);
                    nxt.speed = (grown > CW'(MAX_SPEED)) ? CW'(MAX_SPEED) : grown;
                    nxt.hold  = '0;
                end else begin
                    nxt.hold = cur.hold + HW'(1);
                end
            end
            if (dir == DIR_NEG) delta = -delta;
            nxt.pos = apply_bound(cur.pos + delta, limit);
        end
        nxt.dir = dir;
        return nxt;
    endfunction

    assign btn_raw = {fwd_button, back_button, down_button, up_button, right_button, left_button};

    // Two-flop synchroniser for the asynchronous button levels.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

`ifdef HAND_JOG_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DBW-1:0] db_cnt [6];

    // Flip a filtered level only after the synchronised level has disagreed with it for DEBOUNCE_CYCLES clocks.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            btn_level <= '0;
            for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (sync_b[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                    btn_level[i] <= sync_b[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign btn_level = sync_b;
`endif

    // Free-running motion tick counter; a tick is the cycle where it reads zero.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)                             tick_cnt <= '0;
        else if (tick_cnt == TW'(TICK_CYCLES - 1)) tick_cnt <= '0;
        else                                       tick_cnt <= tick_cnt + 1'b1;
    end

    assign tick = (tick_cnt == '0);

    // Work out every axis's next state and the follower top Y ahead of the tick edge.
    always_comb begin
        cur_x.pos   = CW'(x_q);
        cur_x.speed = speed_q[0];
        cur_x.hold  = hold_q[0];
        cur_x.dir   = dir_q[0];
        cur_y.pos   = CW'(y_q);
        cur_y.speed = speed_q[1];
        cur_y.hold  = hold_q[1];
        cur_y.dir   = dir_q[1];
        cur_z.pos   = CW'(z_q);
        cur_z.speed = speed_q[2];
        cur_z.hold  = hold_q[2];
        cur_z.dir   = dir_q[2];
        nxt_x       = step_axis(cur_x, btn_level[0], btn_level[1], MAX_X);
        nxt_y       = step_axis(cur_y, btn_level[2], btn_level[3], MAX_Y);
        nxt_z       = step_axis(cur_z, btn_level[4], btn_level[5], MAX_Z);
        top_y_next  = apply_bound(nxt_y.pos - CW'(SPAN_Y), MAX_Y);
        moved       = (nxt_x.pos != cur_x.pos) || (nxt_y.pos != cur_y.pos) ||
                      (nxt_z.pos != cur_z.pos);
    end

    // Commit positions, speed ramps and the update strobe together on each tick.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            x_q        <= XY_W'(X_INIT);
            y_q        <= XY_W'(Y_INIT);
            z_q        <= Z_W'(Z_INIT);
            top_y_q    <= XY_W'(apply_bound(CW'(Y_INIT) - CW'(SPAN_Y), MAX_Y));
            hand_valid <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                speed_q[i] <= CW'(BASE_SPEED);
                hold_q[i]  <= '0;
                dir_q[i]   <= DIR_NONE;
            end
        end else begin
            hand_valid <= tick && moved;
            if (tick) begin
                x_q        <= XY_W'(nxt_x.pos);
                y_q        <= XY_W'(nxt_y.pos);
                z_q        <= Z_W'(nxt_z.pos);
                top_y_q    <= XY_W'(top_y_next);
                speed_q[0] <= nxt_x.speed;
                speed_q[1] <= nxt_y.speed;
                speed_q[2] <= nxt_z.speed;
                hold_q[0]  <= nxt_x.hold;
                hold_q[1]  <= nxt_y.hold;
                hold_q[2]  <= nxt_z.hold;
                dir_q[0]   <= nxt_x.dir;
                dir_q[1]   <= nxt_y.dir;
                dir_q[2]   <= nxt_z.dir;
            end
        end
    end

    assign hand_x_left_bottom = x_q;
    assign hand_y_left_bottom = y_q;
    assign hand_z_left_bottom = z_q;
    assign hand_x_left_top    = x_q;
    assign hand_y_left_top    = top_y_q;
    assign hand_z_left_top    = z_q;

endmodule

// File: tb/tb_hand_jog_controller.sv
// tb_hand_jog_controller: two controllers (wrap and saturate) driven by the
// same buttons, checked every cycle against an integer model of the jog rules.

module tb_hand_jog_controller;

    localparam int TICK = 4;
    localparam int SPAN = 200;
    localparam int LEFT = 0, RIGHT = 1, UP = 2, DOWN = 3, BACK = 4, FWD = 5;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic [5:0] btn;

    logic [11:0] xb [2];
    logic [11:0] yb [2];
    logic [13:0] zb [2];
    logic [11:0] xt [2];
    logic [11:0] yt [2];
    logic [13:0] zt [2];
    logic        hv [2];

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit cmp_en    = 1'b0;

    // Model state: index [m] 0 = wrap instance, 1 = saturate instance; [a] axis X/Y/Z.
    int   lim [3] = '{3400, 3400, 500};
    int   pos [2][3];
    int   spd [2][3];
    int   hld [2][3];
    int   ldir[2][3];
    int   topy[2];
    bit   mvalid[2];
    logic [5:0] h1, h2, used;
    int   cyc;
    bit   tick_seen;

    always #5 clk_in = ~clk_in;

    hand_jog_controller #(.TICK_CYCLES(TICK), .WRAP_MODE(1)) dut_wrap (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .left_button(btn[LEFT]), .right_button(btn[RIGHT]),
        .up_button(btn[UP]), .down_button(btn[DOWN]),
        .fwd_button(btn[FWD]), .back_button(btn[BACK]),
        .hand_x_left_bottom(xb[0]), .hand_y_left_bottom(yb[0]), .hand_z_left_bottom(zb[0]),
        .hand_x_left_top(xt[0]), .hand_y_left_top(yt[0]), .hand_z_left_top(zt[0]),
        .hand_valid(hv[0])
    );

    hand_jog_controller #(.TICK_CYCLES(TICK), .WRAP_MODE(0)) dut_sat (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .left_button(btn[LEFT]), .right_button(btn[RIGHT]),
        .up_button(btn[UP]), .down_button(btn[DOWN]),
        .fwd_button(btn[FWD]), .back_button(btn[BACK]),
        .hand_x_left_bottom(xb[1]), .hand_y_left_bottom(yb[1]), .hand_z_left_bottom(zb[1]),
        .hand_x_left_top(xt[1]), .hand_y_left_top(yt[1]), .hand_z_left_top(zt[1]),
        .hand_valid(hv[1])
    );

    function automatic int boundPos(int n, int l, bit wrap);
        if (wrap) return ((n % l) + l) % l;
        if (n < 0) return 0;
        if (n >= l) return l - 1;
        return n;
    endfunction

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            pos[m][0] = 1800; pos[m][1] = 1800; pos[m][2] = 0;
            for (int a = 0; a < 3; a++) begin
                spd[m][a] = 18; hld[m][a] = 0; ldir[m][a] = 0;
            end
            topy[m]   = boundPos(1800 - SPAN, 3400, m == 0);
            mvalid[m] = 1'b0;
        end
    endtask

    task automatic modelAxis(int m, int a, bit neg_b, bit pos_b);
        int d, mv, np;
        d  = (pos_b && !neg_b) ? 1 : ((neg_b && !pos_b) ? -1 : 0);
        mv = 0;
        if (d == 0) begin
            spd[m][a] = 18; hld[m][a] = 0;
        end else if (d != ldir[m][a]) begin
            mv = 18; spd[m][a] = 18; hld[m][a] = 1;
        end else begin
            mv = spd[m][a];
            hld[m][a]++;
            if (hld[m][a] == 8) begin
                spd[m][a] = (spd[m][a] + 18 > 72) ? 72 : spd[m][a] + 18;
                hld[m][a] = 0;
            end
        end
        ldir[m][a] = d;
        np = boundPos(pos[m][a] + d * mv, lim[a], m == 0);
        if (np != pos[m][a]) mvalid[m] = 1'b1;
        pos[m][a] = np;
    endtask

    // Reference model: buttons reach the logic two edges late, motion on every TICK-th edge.
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            modelReset();
            h1 = '0; h2 = '0; cyc = 0; tick_seen = 1'b0;
        end else begin
            used = h2; h2 = h1; h1 = btn;
            tick_seen = (cyc % TICK == 0);
            cyc++;
            for (int m = 0; m < 2; m++) begin
                mvalid[m] = 1'b0;
                if (tick_seen) begin
                    for (int a = 0; a < 3; a++) modelAxis(m, a, used[2*a], used[2*a+1]);
                    topy[m] = boundPos(pos[m][1] - SPAN, 3400, m == 0);
                end
            end
        end
    end

    task automatic checkOutput(string name, int act, int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk_in) begin
        if (cmp_en) begin
            for (int m = 0; m < 2; m++) begin
                checkOutput($sformatf("x_bottom[%0d]", m), int'(xb[m]), pos[m][0]);
                checkOutput($sformatf("y_bottom[%0d]", m), int'(yb[m]), pos[m][1]);
                checkOutput($sformatf("z_bottom[%0d]", m), int'(zb[m]), pos[m][2]);
                checkOutput($sformatf("x_top[%0d]", m), int'(xt[m]), pos[m][0]);
                checkOutput($sformatf("y_top[%0d]", m), int'(yt[m]), topy[m]);
                checkOutput($sformatf("z_top[%0d]", m), int'(zt[m]), pos[m][2]);
                checkOutput($sformatf("valid[%0d]", m), int'(hv[m]), int'(mvalid[m]));
            end
        end
    end

    task automatic waitTick();
        int guard = 0;
        do begin
            @(negedge clk_in);
            guard++;
        end while (!tick_seen && guard < 4 * TICK + 8);
        if (!tick_seen) begin
            total_cnt++;
            $display("[TB] FAIL tick_wait: no tick after %0d cycles, expected one within %0d", guard, TICK);
        end
    endtask

    // Call at the negedge after a tick; vec is held for exactly n ticks.
    task automatic applyStimulus(logic [5:0] vec, int n);
        btn = vec;
        for (int i = 0; i < n; i++) waitTick();
    endtask

    task automatic checkResetValues(string tag);
        for (int m = 0; m < 2; m++) begin
            checkOutput({tag, "_x"}, int'(xb[m]), 1800);
            checkOutput({tag, "_y"}, int'(yb[m]), 1800);
            checkOutput({tag, "_ytop"}, int'(yt[m]), 1600);
            checkOutput({tag, "_z"}, int'(zb[m]), 0);
            checkOutput({tag, "_valid"}, int'(hv[m]), 0);
        end
    endtask

    task automatic pulseReset();
        @(posedge clk_in);
        #1 rst_n_in = 1'b0;
        btn = '0;
        #1 checkResetValues("async_reset");
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        waitTick();
    endtask

    initial begin
        logic [5:0] vec;
        btn      = '0;
        rst_n_in = 1'b1;
        #3 rst_n_in = 1'b0;
        #4 checkResetValues("reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        cmp_en   = 1'b1;
        waitTick();

        // First hold: one tick of right moves x by the base speed.
        applyStimulus(6'b1 << RIGHT, 1);
        checkOutput("one_tick_x", int'(xb[0]), 1818);
        checkOutput("one_tick_xtop", int'(xt[1]), 1818);
        checkOutput("one_tick_ytop", int'(yt[0]), 1600);
        checkOutput("one_tick_valid", int'(hv[0]), 1);
        checkOutput("model_one_tick_x", pos[0][0], 1818);
        applyStimulus('0, 1);
        checkOutput("idle_valid", int'(hv[0]), 0);

        // Nine held ticks: eight at 18, then 36 after the acceleration event.
        applyStimulus(6'b1 << RIGHT, 9);
        checkOutput("accel_x", int'(xb[0]), 1998);
        checkOutput("model_accel_x", pos[1][0], 1998);
        applyStimulus('0, 1);
        applyStimulus(6'b1 << RIGHT, 1);
        checkOutput("rehold_x", int'(xb[1]), 2016);

        // Z boundaries: wrap goes below zero and back to exactly MAX; saturate clamps.
        applyStimulus('0, 1);
        applyStimulus(6'b1 << BACK, 1);
        checkOutput("wrap_z_under", int'(zb[0]), 482);
        checkOutput("sat_z_under", int'(zb[1]), 0);
        applyStimulus('0, 1);
        applyStimulus(6'b1 << FWD, 1);
        checkOutput("wrap_z_over", int'(zb[0]), 0);
        checkOutput("sat_z_up", int'(zb[1]), 18);
        applyStimulus('0, 1);
        applyStimulus(6'b1 << FWD, 20);
        checkOutput("sat_z_ceiling", int'(zb[1]), 499);
        checkOutput("model_sat_z_ceiling", pos[1][2], 499);
        applyStimulus('0, 1);
        applyStimulus(6'b1 << BACK, 1);
        checkOutput("sat_z_back", int'(zb[1]), 481);
        applyStimulus('0, 1);

        // Opposite buttons cancel; an independent axis still moves.
        applyStimulus((6'b1 << LEFT) | (6'b1 << RIGHT), 1);
        checkOutput("cancel_x", int'(xb[0]), 2016);
        checkOutput("cancel_valid", int'(hv[0]), 0);
        applyStimulus((6'b1 << LEFT) | (6'b1 << RIGHT) | (6'b1 << UP), 1);
        checkOutput("cancel_up_x", int'(xb[0]), 2016);
        checkOutput("cancel_up_y", int'(yb[0]), 1782);
        checkOutput("cancel_up_ytop", int'(yt[1]), 1582);
        checkOutput("cancel_up_valid", int'(hv[1]), 1);

        // Reset while moving, then the first move is back at base speed.
        applyStimulus(6'b1 << RIGHT, 3);
        repeat (2) @(negedge clk_in);
        pulseReset();
        applyStimulus(6'b1 << RIGHT, 1);
        checkOutput("post_reset_x", int'(xb[0]), 1818);

        // Randomised holds, with an occasional reset mid-tick.
        for (int s = 0; s < 260; s++) begin
            for (int i = 0; i < 6; i++) vec[i] = ($urandom_range(0, 2) == 0);
            applyStimulus(vec, $urandom_range(1, 14));
            if ($urandom_range(0, 40) == 0) begin
                repeat ($urandom_range(0, TICK - 2)) @(negedge clk_in);
                pulseReset();
            end
        end

        applyStimulus('0, 1);
        cmp_en = 1'b0;
        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hand_jog_controller.md
Name: hand_jog_controller

Overview:
- Parametrised, three-axis button-driven hand-position generator: the test stand-in for the camera tracker, feeding downstream consumers the same bottom/top hand-point interface.
- Adds Z-axis buttons, per-axis hold acceleration, selectable wrap or saturate boundaries, a fixed vertical span between the two points, and a one-cycle update strobe.
- Positions update once per TICK_CYCLES.

Parameters:
- TICK_CYCLES, 1625000, clocks per motion tick (25 ms at 65 MHz); minimum 2.
- XY_W, 12, width of the X/Y coordinates.
- Z_W, 14, width of the Z coordinate.
- MAX_X / MAX_Y / MAX_Z, 3400 / 3400 / 500, exclusive upper bound per axis; valid range is 0..MAX-1.
- X_INIT / Y_INIT / Z_INIT, 1800 / 1800 / 0, reset position of the bottom point.
- SPAN_Y, 200, top_y = bottom_y - SPAN_Y (boundary rule applied); SPAN_Y < MAX_Y.
- BASE_SPEED, 18, units moved per tick on the first tick of a hold.
- MAX_SPEED, 72, speed ceiling.
- ACCEL_STEP, 18, speed increment per acceleration event.
- ACCEL_TICKS, 8, consecutive held ticks per acceleration event.
- WRAP_MODE, 1, 1 = modular wrap, 0 = saturate at 0 / MAX-1.

Ports:
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous active-low reset
- left_button, right_button  in  1  X-/X+ request, asynchronous level
- up_button, down_button  in  1  Y-/Y+ request, asynchronous level
- fwd_button, back_button  in  1  Z+/Z- request, asynchronous level
- hand_x_left_bottom, hand_y_left_bottom  out  XY_W  bottom point X/Y
- hand_z_left_bottom  out  Z_W  bottom point Z
- hand_x_left_top, hand_y_left_top  out  XY_W  top point X/Y
- hand_z_left_top  out  Z_W  top point Z
- hand_valid  out  1  one-cycle pulse when the positions are updated

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Bottom point = (X_INIT, Y_INIT, Z_INIT).
  - Top point = (X_INIT, bounded(Y_INIT - SPAN_Y), Z_INIT).
  - hand_valid = 0; tick counter = 0; per-axis speed = BASE_SPEED; hold count = 0; last direction = none.
  - Synchronisers cleared.
  - Reset mid-tick discards any pending update.
- Inputs: every button passes a 2-flop synchroniser. Only the synchronised values are used.
- Tick counter: counts 0..TICK_CYCLES-1, then wraps. A tick occurs when the count is 0. The first tick is the first cycle after reset release.
- Per axis, at each tick:
  - Direction: the negative button alone = -1; the positive button alone = +1; both or neither = none.
  - Direction none: no motion; speed = BASE_SPEED; hold = 0.
  - Direction differs from last tick's direction: move by BASE_SPEED; speed = BASE_SPEED; hold = 1.
  - Same direction as last tick: move by the current speed; hold += 1. When hold reaches ACCEL_TICKS, set speed = min(speed + ACCEL_STEP, MAX_SPEED) and hold = 0. The new speed applies from the next tick.
  - Axes are fully independent.
- Boundary rule, with n = pos + delta computed in signed width max(XY_W, Z_W) + 2:
  - WRAP_MODE = 1: n >= MAX gives n - MAX; n < 0 gives n + MAX.
  - WRAP_MODE = 0: clamp to 0 or MAX-1.
  - Exact boundary cases: a result equal to MAX-1 or 0 is kept as is.
- Top point:
  - x_top = x_bottom and z_top = z_bottom.
  - y_top = new y_bottom - SPAN_Y, with the boundary rule applied.
  - All six outputs are registered on the same clock edge.
- hand_valid is high for exactly the cycle after a tick in which at least one axis moved, i.e. the first cycle the new values are visible.
- Latency: a button edge reaches the outputs no later than 2 + TICK_CYCLES clocks.
- Outputs never leave the range 0..MAX-1.

Optional Feature:
- Macro: HAND_JOG_DEBOUNCE_EN.
- Defined:
  - Each synchronised button feeds a debouncer with parameter DEBOUNCE_CYCLES (default 65000).
  - The filtered level changes only after the raw level has been stable for DEBOUNCE_CYCLES consecutive clocks.
  - Filtered levels reset to 0.
- Undefined: synchronised levels are used directly, and DEBOUNCE_CYCLES is ignored.

Test Plan (TICK_CYCLES = 4, defaults otherwise):
- Reset, then hold right_button for 1 tick -> x = 1818 on both points; y_bottom = 1800, y_top = 1600; hand_valid pulses once.
- Hold right_button for 9 ticks -> steps of 18 for 8 ticks, then 36 on the 9th tick; x = 1800 + 8×18 + 36 = 1980. Release -> next hold moves by 18 again.
- WRAP_MODE = 1, x = 3390, one right tick -> x = 8. Then a left tick from x = 8 at speed 18 -> 3390.
- WRAP_MODE = 0, z = 490, hold fwd_button -> z = 499 and stays there. Pressing back_button alone -> 481.
- left_button and right_button both held -> x unchanged, no hand_valid. Up held at the same time -> y moves and hand_valid pulses.
- Assert rst_n_in low mid-tick while moving -> outputs return asynchronously to their reset values. After release, the first tick moves at BASE_SPEED.
